// File: rtl/axis_pkt_sink_if.sv
// axis_pkt_sink_if: 64-bit AXI4-Stream bundle between a stream source and axis_pkt_sink.
// Handshake: a beat transfers on a rising CLK edge where tvalid and tready are both high;
// tready from the sink is registered and never depends on tvalid.
interface axis_pkt_sink_if;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pkt_sink.sv
// axis_pkt_sink: AXI4-Stream packet sink that checks length and tkeep and keeps packet stats.
// Programmable backpressure (LFSR / one-in-four / never) is built only when AXIS_SINK_BP_EN is defined.
module axis_pkt_sink #(
   parameter int unsigned MAX_BEATS = 190,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                  CLK,
   input  logic                  ARESETN,
   axis_pkt_sink_if.slave        S_AXIS,
   input  logic [1:0]            bp_mode,
   input  logic                  err_clr,
   output logic                  pkt_done,
   output logic [15:0]           pkt_beats,
   output logic [15:0]           pkt_bytes,
   output logic [63:0]           first_word,
   output logic [31:0]           pkt_count,
   output logic [15:0]           drop_count,
   output logic                  err_keep,
   output logic                  err_len,
   output logic [1:0]            dbg_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BODY  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [15:0] MAX_B16 = 16'(MAX_BEATS);

   logic [1:0]  state_q, state_d;
   logic [15:0] beat_cnt_q, beat_cnt_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [63:0] first_q, first_d;
   logic        tready_q, tready_d;
   logic        pkt_done_q, pkt_done_d;
   logic [15:0] pkt_beats_q, pkt_beats_d;
   logic [15:0] pkt_bytes_q, pkt_bytes_d;
   logic [63:0] first_word_q, first_word_d;
   logic [31:0] pkt_count_q, pkt_count_d;
   logic [15:0] drop_count_q, drop_count_d;
   logic        err_keep_q, err_keep_d;
   logic        err_len_q, err_len_d;

   logic        accept;
   logic        keep_ok;
   logic        keep_evt, len_evt, drop_evt, cmpl;
   logic [15:0] beat_n;
   logic [15:0] cmpl_beats, cmpl_bytes;
   logic [63:0] cmpl_first;

   function automatic logic [15:0] keep_bytes(input logic [7:0] k);
      logic [15:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {15'd0, k[i]};
      return n;
   endfunction

   assign accept = S_AXIS.tvalid & tready_q;

   // Last beats may only trim bytes from the top; every other beat must be full.
   always_comb begin
      keep_ok = 1'b0;
      if (!S_AXIS.tlast) begin
         keep_ok = (S_AXIS.tkeep == 8'hFF);
      end else begin
         case (S_AXIS.tkeep)
            8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF: keep_ok = 1'b1;
            default: keep_ok = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      first_d      = first_q;
      keep_evt     = 1'b0;
      len_evt      = 1'b0;
      drop_evt     = 1'b0;
      cmpl         = 1'b0;
      cmpl_beats   = '0;
      cmpl_bytes   = '0;
      cmpl_first   = '0;
      beat_n       = beat_cnt_q + 16'd1;

      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               keep_evt = ~keep_ok;
               if (S_AXIS.tlast) begin
                  cmpl       = 1'b1;
                  cmpl_beats = 16'd1;
                  cmpl_bytes = keep_bytes(S_AXIS.tkeep);
                  cmpl_first = S_AXIS.tdata;
               end else begin
                  state_d    = ST_BODY;
                  beat_cnt_d = 16'd1;
                  byte_cnt_d = 16'd8;
                  first_d    = S_AXIS.tdata;
               end
            end
            ST_BODY: begin
               keep_evt = ~keep_ok;
               // A beat that pushes the count past MAX_BEATS kills the packet, last or not.
               if (beat_n > MAX_B16) begin
                  len_evt = 1'b1;
                  if (S_AXIS.tlast) begin
                     drop_evt = 1'b1;
                     state_d  = ST_IDLE;
                  end else begin
                     state_d  = ST_DRAIN;
                  end
               end else if (S_AXIS.tlast) begin
                  cmpl       = 1'b1;
                  cmpl_beats = beat_n;
                  cmpl_bytes = byte_cnt_q + keep_bytes(S_AXIS.tkeep);
                  cmpl_first = first_q;
                  state_d    = ST_IDLE;
               end else begin
                  beat_cnt_d = beat_n;
                  byte_cnt_d = byte_cnt_q + 16'd8;
               end
            end
            ST_DRAIN: begin
               if (S_AXIS.tlast) begin
                  drop_evt = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      pkt_done_d   = cmpl;
      pkt_beats_d  = cmpl ? cmpl_beats : pkt_beats_q;
      pkt_bytes_d  = cmpl ? cmpl_bytes : pkt_bytes_q;
      first_word_d = cmpl ? cmpl_first : first_word_q;
      pkt_count_d  = cmpl ? pkt_count_q + 32'd1 : pkt_count_q;
      drop_count_d = drop_count_q;
      if (drop_evt && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
      // A new error in the clearing cycle must survive the clear.
      err_keep_d = (err_keep_q & ~err_clr) | keep_evt;
      err_len_d  = (err_len_q & ~err_clr) | len_evt;
   end

`ifdef AXIS_SINK_BP_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic [1:0]  mode_cnt_q, mode_cnt_d;

   // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, stepped every cycle.
   always_comb begin
      lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      mode_cnt_d = mode_cnt_q + 2'd1;
      case (bp_mode)
         2'd0:    tready_d = 1'b1;
         2'd1:    tready_d = lfsr_d[0];
         2'd2:    tready_d = (mode_cnt_d == 2'd3);
         default: tready_d = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!ARESETN) begin
         lfsr_q     <= LFSR_SEED;
         mode_cnt_q <= 2'd0;
      end else begin
         lfsr_q     <= lfsr_d;
         mode_cnt_q <= mode_cnt_d;
      end
   end
`else
   logic unused_bp_cfg;
   assign unused_bp_cfg = ^{bp_mode, LFSR_SEED};
   assign tready_d      = 1'b1;
`endif

   always_ff @(posedge CLK) begin
      if (!ARESETN) begin
         state_q      <= ST_IDLE;
         beat_cnt_q   <= '0;
         byte_cnt_q   <= '0;
         first_q      <= '0;
         tready_q     <= 1'b0;
         pkt_done_q   <= 1'b0;
         pkt_beats_q  <= '0;
         pkt_bytes_q  <= '0;
         first_word_q <= '0;
         pkt_count_q  <= '0;
         drop_count_q <= '0;
         err_keep_q   <= 1'b0;
         err_len_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         first_q      <= first_d;
         tready_q     <= tready_d;
         pkt_done_q   <= pkt_done_d;
         pkt_beats_q  <= pkt_beats_d;
         pkt_bytes_q  <= pkt_bytes_d;
         first_word_q <= first_word_d;
         pkt_count_q  <= pkt_count_d;
         drop_count_q <= drop_count_d;
         err_keep_q   <= err_keep_d;
         err_len_q    <= err_len_d;
      end
   end

   assign S_AXIS.tready = tready_q;
   assign pkt_done      = pkt_done_q;
   assign pkt_beats     = pkt_beats_q;
   assign pkt_bytes     = pkt_bytes_q;
   assign first_word    = first_word_q;
   assign pkt_count     = pkt_count_q;
   assign drop_count    = drop_count_q;
   assign err_keep      = err_keep_q;
   assign err_len       = err_len_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_pkt_sink.sv
// tb_axis_pkt_sink: randomized packets against a packet-level reference model of axis_pkt_sink.
// The tready expectation follows AXIS_SINK_BP_EN the same way the design build does.
module tb_axis_pkt_sink;

   localparam int MAXB = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        CLK;
   logic        ARESETN;
   logic [1:0]  bp_mode;
   logic        err_clr;
   logic        pkt_done;
   logic [15:0] pkt_beats, pkt_bytes, drop_count;
   logic [63:0] first_word;
   logic [31:0] pkt_count;
   logic        err_keep, err_len;
   logic [1:0]  dbg_state;

   axis_pkt_sink_if s_axis ();

   axis_pkt_sink #(.MAX_BEATS(MAXB), .LFSR_SEED(SEED)) dut (
      .CLK(CLK), .ARESETN(ARESETN), .S_AXIS(s_axis), .bp_mode(bp_mode), .err_clr(err_clr),
      .pkt_done(pkt_done), .pkt_beats(pkt_beats), .pkt_bytes(pkt_bytes), .first_word(first_word),
      .pkt_count(pkt_count), .drop_count(drop_count), .err_keep(err_keep), .err_len(err_len),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] pd[$];
   logic [7:0]  pk[$];
   logic        m_done = 0;
   logic [15:0] m_beats = 0, m_bytes = 0, m_drop = 0;
   logic [63:0] m_first = 0;
   logic [31:0] m_pkt_count = 0;
   logic        m_err_keep = 0, m_err_len = 0;
   logic        e_tready = 0;
   int          m_k = 0;
   logic [15:0] m_lfsr = SEED;

   function automatic logic lfsr_taps(input logic [15:0] l);
      return l[0] ^ l[2] ^ l[3] ^ l[5];
   endfunction

   function automatic logic legal_last(input logic [7:0] k);
      return (k != 8'h00) && ((k & (k + 8'h01)) == 8'h00);
   endfunction

   task automatic close_packet();
      int n, lim;
      logic bad;
      n   = pd.size();
      lim = (n > MAXB + 1) ? MAXB + 1 : n;
      bad = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (i == n - 1) bad = bad | !legal_last(pk[i]);
         else            bad = bad | (pk[i] != 8'hFF);
      end
      if (bad) m_err_keep = 1'b1;
      if (n <= MAXB) begin
         m_done      = 1'b1;
         m_beats     = 16'(n);
         m_bytes     = 16'(8 * (n - 1) + $countones(pk[n-1]));
         m_first     = pd[0];
         m_pkt_count = m_pkt_count + 32'd1;
      end else begin
         m_err_len = 1'b1;
         if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      pd.delete();
      pk.delete();
   endtask

   // Outputs at each falling edge reflect every beat the model absorbed before it.
   always @(negedge CLK) begin
      chk("tready", {63'd0, s_axis.tready}, {63'd0, e_tready});
      chk("pkt_done", {63'd0, pkt_done}, {63'd0, m_done});
      chk("pkt_count", {32'd0, pkt_count}, {32'd0, m_pkt_count});
      chk("drop_count", {48'd0, drop_count}, {48'd0, m_drop});
      chk("pkt_beats", {48'd0, pkt_beats}, {48'd0, m_beats});
      chk("pkt_bytes", {48'd0, pkt_bytes}, {48'd0, m_bytes});
      chk("first_word", first_word, m_first);
      if (pd.size() == 0) begin
         chk("err_keep", {63'd0, err_keep}, {63'd0, m_err_keep});
         chk("err_len", {63'd0, err_len}, {63'd0, m_err_len});
      end
      m_done = 1'b0;
      if (!ARESETN) begin
         pd.delete();
         pk.delete();
         m_beats = 0; m_bytes = 0; m_drop = 0; m_first = 0; m_pkt_count = 0;
         m_err_keep = 0; m_err_len = 0; e_tready = 0; m_k = 0; m_lfsr = SEED;
      end else begin
         if (err_clr) begin
            m_err_keep = 1'b0;
            m_err_len  = 1'b0;
         end
         if (s_axis.tvalid && s_axis.tready) begin
            pd.push_back(s_axis.tdata);
            pk.push_back(s_axis.tkeep);
            if (s_axis.tlast) close_packet();
         end
         m_k    = m_k + 1;
         m_lfsr = {lfsr_taps(m_lfsr), m_lfsr[15:1]};
`ifdef AXIS_SINK_BP_EN
         case (bp_mode)
            2'd0: e_tready = 1'b1;
            2'd1: e_tready = m_lfsr[0];
            2'd2: e_tready = ((m_k % 4) == 3);
            default: e_tready = 1'b0;
         endcase
`else
         e_tready = 1'b1;
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      s_axis.tvalid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      logic acc;
      int   budget;
      acc    = 1'b0;
      budget = 64;
      s_axis.tdata  = d;
      s_axis.tkeep  = k;
      s_axis.tlast  = l;
      s_axis.tvalid = 1'b1;
      while (!acc && budget > 0) begin
         @(negedge CLK);
         acc = s_axis.tready;
         tick();
         budget--;
      end
      if (!acc) chk("accept_timeout", {63'd0, acc}, 64'd1);
      s_axis.tvalid = 1'b0;
   endtask

   task automatic send_pkt(input int len, input logic bad_keep_ok);
      logic [7:0] k;
      for (int b = 0; b < len; b++) begin
         if (b == len - 1) k = 8'hFF >> $urandom_range(0, 7);
         else              k = 8'hFF;
         if (bad_keep_ok && $urandom_range(0, 9) == 0) k = 8'($urandom_range(0, 255));
         send_beat({$urandom, $urandom}, k, b == len - 1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
   endtask

   task automatic pulse_clr();
      s_axis.tvalid = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic got;
      ARESETN = 1'b0;
      bp_mode = 2'd0;
      err_clr = 1'b0;
      s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0; s_axis.tvalid = 1'b0;
      repeat (3) tick();
      ARESETN = 1'b1;
      idle(2);

      // Three-beat packet with a 4-byte tail
      send_beat(64'h0000007447C0887A, 8'hFF, 1'b0);
      send_beat(64'h0100000100030000, 8'hFF, 1'b0);
      send_beat(64'h5073930200000000, 8'h0F, 1'b1);
      @(negedge CLK);
      chk("ex_bytes", {48'd0, pkt_bytes}, 64'd20);
      chk("ex_first", first_word, 64'h0000007447C0887A);
      tick();

      // Sparse tkeep on a single-beat packet, then clear
      send_beat(64'h1122334455667788, 8'h05, 1'b1);
      idle(1);
      pulse_clr();
      idle(1);

      // Overlong packet, exact-limit packet, one-over-limit last beat
      send_pkt(6, 1'b0);
      idle(1);
      send_pkt(MAXB, 1'b0);
      idle(1);
      send_pkt(MAXB + 1, 1'b0);
      idle(1);
      pulse_clr();

      // Keep error in the same cycle as err_clr must stick
      idle(1);
      err_clr = 1'b1;
      send_beat(64'hDEADBEEF00000001, 8'h0A, 1'b1);
      err_clr = 1'b0;
      idle(2);

      // Reset in the middle of a packet, then a fresh packet
      send_beat(64'hAAAA000000000000, 8'hFF, 1'b0);
      send_beat(64'hAAAA000000000001, 8'hFF, 1'b0);
      ARESETN = 1'b0;
      tick();
      ARESETN = 1'b1;
      send_beat(64'hBBBB000000000000, 8'hFF, 1'b0);
      send_beat(64'hBBBB000000000001, 8'h3F, 1'b1);
      idle(2);

      // Never-ready mode with a beat held, then release in mode 0
      bp_mode = 2'd3;
      idle(3);
      s_axis.tdata = 64'hC0FFEE0000000000; s_axis.tkeep = 8'h7F; s_axis.tlast = 1'b1;
      s_axis.tvalid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (s_axis.tready) got = 1'b1;
         tick();
         if (got) s_axis.tvalid = 1'b0;
      end
      bp_mode = 2'd0;
      if (!got) send_beat(64'hC0FFEE0000000000, 8'h7F, 1'b1);
      idle(2);

      // Randomized packets across backpressure modes
      for (int p = 0; p < 250; p++) begin
         if ($urandom_range(0, 4) == 0) bp_mode = 2'($urandom_range(0, 2));
         send_pkt($urandom_range(1, MAXB + 2), 1'b1);
         if ($urandom_range(0, 7) == 0) pulse_clr();
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      bp_mode = 2'd0;
      idle(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
